// File: rtl/bresenham_line.sv
// rtl/bresenham_line.sv - Bresenham line traversal engine streaming grid cells
// Latches a segment on start, then emits every cell from (x0,y0) to (x1,y1) over valid/ready.
module bresenham_line #(
  parameter int COORD_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [COORD_WIDTH-1:0] x0,
  input  logic signed [COORD_WIDTH-1:0] y0,
  input  logic signed [COORD_WIDTH-1:0] x1,
  input  logic signed [COORD_WIDTH-1:0] y1,
  output logic                          busy,
  output logic                          point_valid,
  input  logic                          point_ready,
  output logic signed [COORD_WIDTH-1:0] point_x,
  output logic signed [COORD_WIDTH-1:0] point_y,
  output logic                          point_last
);
  localparam int W = COORD_WIDTH;
  localparam logic [W-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  state_t state, state_next;

  logic signed [W-1:0] lx0, ly0, lx1, ly1;
  logic signed [W-1:0] cur_x, cur_y;
  logic        [W:0]   dx;
  logic signed [W+1:0] dy, err;
  logic                sx_pos, sy_pos;

  logic signed [W:0]   diff_x, diff_y;
  logic        [W:0]   abs_x, abs_y;
  logic signed [W+2:0] e2, dx_wide, dy_wide;
  logic signed [W+1:0] dx_err, err_next;
  logic                step_x, step_y, at_end;

  // One extra bit keeps the endpoint difference exact across the full signed range.
  assign diff_x = {lx1[W-1], lx1} - {lx0[W-1], lx0};
  assign diff_y = {ly1[W-1], ly1} - {ly0[W-1], ly0};
  assign abs_x  = diff_x[W] ? -diff_x : diff_x;
  assign abs_y  = diff_y[W] ? -diff_y : diff_y;

  assign e2      = {err, 1'b0};
  assign dx_wide = {2'b00, dx};
  assign dy_wide = {dy[W+1], dy};
  assign dx_err  = {1'b0, dx};
  assign step_x  = (e2 >= dy_wide);
  assign step_y  = (e2 <= dx_wide);
  assign err_next = err + (step_x ? dy : '0) + (step_y ? dx_err : '0);
  assign at_end  = (cur_x == lx1) && (cur_y == ly1);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    point_valid = 1'b0;
    point_last  = 1'b0;
    point_x     = '0;
    point_y     = '0;
    case (state)
      IDLE:  if (start) state_next = SETUP;
      SETUP: begin
        busy       = 1'b1;
        state_next = DRAW;
      end
      DRAW: begin
        busy        = 1'b1;
        point_valid = 1'b1;
        point_last  = at_end;
        point_x     = cur_x;
        point_y     = cur_y;
        if (point_ready && at_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          lx0 <= x0;
          ly0 <= y0;
          lx1 <= x1;
          ly1 <= y1;
        end
        SETUP: begin
          dx     <= abs_x;
          dy     <= -$signed({1'b0, abs_y});
          err    <= $signed({1'b0, abs_x}) - $signed({1'b0, abs_y});
          sx_pos <= (lx1 > lx0);
          sy_pos <= (ly1 > ly0);
          cur_x  <= lx0;
          cur_y  <= ly0;
        end
        DRAW: if (point_ready && !at_end) begin
          // Both axis decisions use the pre-step error term.
          err <= err_next;
          if (step_x) cur_x <= sx_pos ? cur_x + ONE : cur_x - ONE;
          if (step_y) cur_y <= sy_pos ? cur_y + ONE : cur_y - ONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bresenham_line.sv
// tb/tb_bresenham_line.sv - scoreboard testbench for bresenham_line
// Expected cells are queued per line and popped as each handshake is committed.
module tb_bresenham_line;
  logic clock = 1'b0;
  logic reset, start, point_ready;
  logic signed [15:0] x0, y0, x1, y1, point_x, point_y;
  logic busy, point_valid, point_last;

  logic s_start, s_ready, s_busy, s_valid, s_last;
  logic signed [3:0] s_x0, s_y0, s_x1, s_y1, s_px, s_py;

  int checks = 0;
  int errors = 0;

  typedef struct {int x; int y; bit last;} pt_t;
  pt_t exp_q[$];

  always #5 clock = ~clock;

  bresenham_line #(.COORD_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .point_valid(point_valid), .point_ready(point_ready),
    .point_x(point_x), .point_y(point_y), .point_last(point_last)
  );

  bresenham_line #(.COORD_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(s_start),
    .x0(s_x0), .y0(s_y0), .x1(s_x1), .y1(s_y1),
    .busy(s_busy), .point_valid(s_valid), .point_ready(s_ready),
    .point_x(s_px), .point_y(s_py), .point_last(s_last)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_pt(input int x, input int y, input bit last);
    pt_t p;
    p.x = x; p.y = y; p.last = last;
    exp_q.push_back(p);
  endtask

  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int stall, input int inj_cycle, input int rst_cycle);
    int cyc, idx, wait_cnt, n, hx, hy;
    bit held_v, hl, done, last_taken;
    pt_t e;
    n = exp_q.size();
    @(negedge clock);
    start = 1'b1;
    x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
    cyc = 0; idx = 0; wait_cnt = 0; held_v = 0; done = 0; last_taken = 0;
    hx = 0; hy = 0; hl = 0;
    point_ready = (stall == 0);
    while (!done && cyc < 300) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        check("setup_busy", busy, 1);
        check("setup_valid", point_valid, 0);
        check("setup_x", point_x, 0);
      end
      if (rst_cycle > 0 && cyc == rst_cycle + 1) begin
        check("rst_busy", busy, 0);
        check("rst_valid", point_valid, 0);
        check("rst_last", point_last, 0);
        check("rst_x", point_x, 0);
        check("rst_y", point_y, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) begin
          @(negedge clock);
          check("no_pts_after_reset", point_valid, 0);
        end
        done = 1;
      end else if (last_taken) begin
        check("end_busy", busy, 0);
        check("end_valid", point_valid, 0);
        if (stall == 0) check("end_cycle", cyc, n + 2);
        done = 1;
      end else if (point_valid) begin
        if (held_v) begin
          check("stall_x", point_x, hx);
          check("stall_y", point_y, hy);
          check("stall_last", point_last, hl);
        end
        point_ready = (wait_cnt >= stall);
        if (point_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_point", 1, 0);
            done = 1;
          end else begin
            e = exp_q.pop_front();
            check("pt_x", point_x, e.x);
            check("pt_y", point_y, e.y);
            check("pt_last", point_last, e.last);
            last_taken = e.last;
          end
          if (stall == 0) check("pt_cycle", cyc, idx + 2);
          idx++; wait_cnt = 0; held_v = 0;
        end else begin
          wait_cnt++; held_v = 1;
          hx = point_x; hy = point_y; hl = point_last;
        end
      end else if (cyc > 1) begin
        check("valid_gap", point_valid, 1);
      end
      if (cyc == inj_cycle) begin
        start = 1'b1;
        x0 = 16'sd5; y0 = 16'sd5; x1 = 16'sd0; y1 = 16'sd0;
      end
      if (cyc == rst_cycle) reset = 1'b1;
    end
    if (!done) check("timeout", 0, 1);
    check("leftover", exp_q.size(), 0);
    point_ready = 1'b1;
  endtask

  initial begin
    int cnt;
    bit fin;
    reset = 1'b1; start = 1'b0; point_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    s_start = 1'b0; s_ready = 1'b1;
    s_x0 = '0; s_y0 = '0; s_x1 = '0; s_y1 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_valid", point_valid, 0);
    check("reset_last", point_last, 0);
    check("reset_x", point_x, 0);
    check("reset_y", point_y, 0);
    reset = 1'b0;

    for (int i = 0; i <= 5; i++) push_pt(i, 0, i == 5);
    run_line(0, 0, 5, 0, 0, 0, 0);

    push_pt(0, 0, 0); push_pt(0, 1, 0); push_pt(1, 2, 0);
    push_pt(1, 3, 0); push_pt(2, 4, 0); push_pt(2, 5, 1);
    run_line(0, 0, 2, 5, 0, 0, 0);

    for (int i = 3; i >= 0; i--) push_pt(i, i, i == 0);
    run_line(3, 3, 0, 0, 0, 0, 0);

    push_pt(7, -4, 1);
    run_line(7, -4, 7, -4, 0, 0, 0);

    push_pt(0, 0, 0); push_pt(-1, -1, 0); push_pt(-2, -1, 0);
    push_pt(-3, -2, 0); push_pt(-4, -2, 1);
    run_line(0, 0, -4, -2, 0, 0, 0);

    push_pt(0, 0, 0); push_pt(1, 0, 0); push_pt(2, 1, 0); push_pt(3, 1, 1);
    run_line(0, 0, 3, 1, 3, 0, 0);

    for (int i = 0; i <= 9; i++) push_pt(i, i, i == 9);
    run_line(0, 0, 9, 9, 0, 4, 0);

    for (int i = 0; i <= 9; i++) push_pt(i, i, i == 9);
    run_line(0, 0, 9, 9, 0, 0, 5);

    for (int i = -2; i <= 1; i++) push_pt(i, 1, i == 1);
    run_line(-2, 1, 1, 1, 0, 0, 0);

    @(negedge clock);
    s_start = 1'b1; s_x0 = -4'sd8; s_y0 = 4'sd0; s_x1 = 4'sd7; s_y1 = 4'sd0;
    @(negedge clock);
    s_start = 1'b0;
    cnt = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clock);
      if (s_valid) begin
        check("w4_x", s_px, -8 + cnt);
        check("w4_y", s_py, 0);
        check("w4_last", s_last, cnt == 15);
        cnt++;
        if (s_last) fin = 1;
      end
    end
    check("w4_count", cnt, 16);
    @(negedge clock);
    check("w4_idle", s_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bresenham_line.md
# bresenham_line

Line-traversal engine that answers the mapping controller's start/busy handshake. It latches a segment (robot cell to scan-endpoint cell) on `start` and raises `busy` while drawing. It streams every grid cell on the segment, in order, to the occupancy-grid updater through a valid/ready handshake. The last cell is flagged so the updater marks it occupied and all earlier cells free.

## Interface
Parameters:
- `COORD_WIDTH`, default 16, width of each signed two's-complement cell coordinate.

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request from the controller; sampled only in IDLE
- `x0`, `y0`  in  COORD_WIDTH  signed start cell; sampled with `start`
- `x1`, `y1`  in  COORD_WIDTH  signed end cell; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `point_valid`  out  1  `point_x`/`point_y` hold a cell of the line
- `point_ready`  in  1  updater accepts the cell this cycle
- `point_x`, `point_y`  out  COORD_WIDTH  signed current cell
- `point_last`  out  1  qualifies `point_valid`; the current cell equals (x1, y1)

## Operation
- States: IDLE, SETUP, DRAW.
- IDLE:
  - `start`=1 latches x0, y0, x1, y1 and moves to SETUP.
  - `start`=0 stays in IDLE.
- SETUP (one cycle) computes and registers:
  - dx = |x1−x0| (unsigned, COORD_WIDTH+1 bits)
  - dy = −|y1−y0| (signed, COORD_WIDTH+2 bits)
  - sx = +1 if x1>x0, else −1
  - sy = +1 if y1>y0, else −1
  - err = dx+dy (signed, COORD_WIDTH+2 bits)
  - current cell = (x0, y0)
  - Then moves to DRAW.
- DRAW:
  - `point_valid`=1 with the current cell.
  - `point_last`=1 when the current cell equals (x1, y1).
  - On handshake (valid && ready) with `point_last`=1: go to IDLE.
  - On handshake otherwise, step once:
    - e2 = 2·err (COORD_WIDTH+3 bits).
    - If e2 ≥ dy: err += dy, x += sx.
    - If e2 ≤ dx: err += dx, y += sy.
    - Both updates use the pre-step err and apply in the same cycle.
  - Without a handshake, hold all registers.
- The step covers all eight octants with no special casing. Intermediate arithmetic never overflows for any coordinate pair in the signed COORD_WIDTH range.
- A `start` outside IDLE is ignored. The latched endpoints are not disturbed.
- Degenerate segment (x0, y0) = (x1, y1): exactly one point, with `point_last`=1.
- `reset` in any state:
  - Next state is IDLE.
  - All outputs are 0 on the following cycle.
  - Any partial line is discarded; no further points are emitted.
- Reset values: `busy`=0, `point_valid`=0, `point_last`=0, `point_x`=0, `point_y`=0.
- Outside DRAW, `point_x`, `point_y` and `point_last` are 0.

## Timing
- `busy` and `point_valid` decode from registered state; there is no combinational path from `start` to any output.
- `point_valid`, `point_last` and `point_x`/`point_y` do not depend combinationally on `point_ready`.
- Define cycle 0 as the cycle where `start`=1 is sampled in IDLE:
  - `busy`=1 from cycle 1 (SETUP).
  - First point is valid at cycle 2.
- With `point_ready` held high, an N-point line emits one point per cycle on cycles 2..N+1, and `busy`=0 at cycle N+2.
- N = max(|x1−x0|, |y1−y0|) + 1.
- Backpressure: while `point_valid`=1 and `point_ready`=0, `point_x`, `point_y` and `point_last` stay stable.
- The earliest next accepted `start` is the first cycle with `busy`=0.
  - The controller pulses `start` only after seeing `busy`=0, so a back-to-back request lands at cycle N+2 at the earliest.

## Test plan
- **Horizontal line.** (0,0)→(5,0), ready=1 → points (0,0)…(5,0) on cycles 2–7; last only on (5,0); busy low at cycle 8.
- **Steep line.** (0,0)→(2,5), ready=1 → points (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
- **Negative-octant diagonal.** (3,3)→(0,0) → points (3,3),(2,2),(1,1),(0,0).
- **Single point and extreme range.** (7,−4)→(7,−4) → one point, with last=1 on cycle 2. Separately, with COORD_WIDTH=4, (−8,0)→(7,0) → 16 points with no wrap.
- **Backpressure.** Line (0,0)→(3,1); drop ready for 3 cycles on each point → every point is held stable while stalled; sequence (0,0),(1,0),(2,1),(3,1); no duplicates, no drops.
- **Start while busy, then reset.** Start (0,0)→(9,9). Pulse start with (5,5)→(0,0) at cycle 4 → ignored, and the line still ends at (9,9). On a rerun, assert reset at cycle 5 → all outputs 0 at cycle 6; no further points; next start works normally.
